// File: rtl/core_sfr_pkg.sv
// Shared definitions for the SFR bank: address map, reset values, PSW bit
// positions, register select and FSM state encodings.
package core_sfr_pkg;

  localparam logic [7:0] ADDR_P0   = 8'h80;
  localparam logic [7:0] ADDR_SP   = 8'h81;
  localparam logic [7:0] ADDR_DPL  = 8'h82;
  localparam logic [7:0] ADDR_DPH  = 8'h83;
  localparam logic [7:0] ADDR_PCON = 8'h87;
  localparam logic [7:0] ADDR_IE   = 8'hA8;
  localparam logic [7:0] ADDR_IP   = 8'hB8;
  localparam logic [7:0] ADDR_PSW  = 8'hD0;
  localparam logic [7:0] ADDR_ACC  = 8'hE0;
  localparam logic [7:0] ADDR_B    = 8'hF0;

  localparam logic [7:0] RST_P0    = 8'hFF;
  localparam logic [7:0] RST_SP    = 8'h07;
  localparam logic [7:0] RST_OTHER = 8'h00;

  localparam int PSW_CY  = 7;
  localparam int PSW_AC  = 6;
  localparam int PSW_RS1 = 4;
  localparam int PSW_RS0 = 3;
  localparam int PSW_OV  = 2;
  localparam int PSW_P   = 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_RESP = 2'd1,
    ST_BIT_RMW = 2'd2
  } sfr_state_e;

  typedef enum logic [3:0] {
    SEL_P0   = 4'd0,
    SEL_SP   = 4'd1,
    SEL_DPL  = 4'd2,
    SEL_DPH  = 4'd3,
    SEL_PCON = 4'd4,
    SEL_IE   = 4'd5,
    SEL_IP   = 4'd6,
    SEL_PSW  = 4'd7,
    SEL_ACC  = 4'd8,
    SEL_B    = 4'd9
  } sfr_sel_e;

  localparam int NUM_SFR = 10;

  function automatic logic [7:0] sfr_rst_val(input int idx);
    if (idx == int'(SEL_P0)) return RST_P0;
    if (idx == int'(SEL_SP)) return RST_SP;
    return RST_OTHER;
  endfunction

  function automatic logic is_bit_row(input logic [7:0] row);
    return (row == ADDR_P0) || (row == ADDR_IE) || (row == ADDR_IP) ||
           (row == ADDR_PSW) || (row == ADDR_ACC) || (row == ADDR_B);
  endfunction

endpackage

// File: rtl/core_sfr_bank_if.sv
// SFR bus bundle: address, active-low strobes, access type, data and status.
interface core_sfr_bank_if;
  logic [7:0] sfr_addr_i;
  logic       sfr_rd_i_b;
  logic       sfr_wr_i_b;
  logic       sfr_bit_byte_flag_i;
  logic [7:0] sfr_data_i;
  logic [7:0] sfr_data_o;
  logic       sfr_rdy_o;
  logic       sfr_err_o;

  modport master (
    output sfr_addr_i, sfr_rd_i_b, sfr_wr_i_b, sfr_bit_byte_flag_i, sfr_data_i,
    input  sfr_data_o, sfr_rdy_o, sfr_err_o
  );

  modport slave (
    input  sfr_addr_i, sfr_rd_i_b, sfr_wr_i_b, sfr_bit_byte_flag_i, sfr_data_i,
    output sfr_data_o, sfr_rdy_o, sfr_err_o
  );
endinterface

// File: rtl/core_sfr_decode.sv
// Combinational address decode: register select, mapped flag and bit index.
// For bit accesses mapped also implies the row is bit-addressable.
module core_sfr_decode
  import core_sfr_pkg::*;
(
  input  logic [7:0] addr_i,
  input  logic       bit_access_i,
  output sfr_sel_e   sel_o,
  output logic       mapped_o,
  output logic [2:0] bit_idx_o
);

  logic [7:0] byte_addr;

  always_comb begin
    byte_addr = bit_access_i ? {addr_i[7:3], 3'b000} : addr_i;
    bit_idx_o = addr_i[2:0];
    sel_o     = SEL_P0;
    mapped_o  = 1'b1;
    case (byte_addr)
      ADDR_P0:   sel_o = SEL_P0;
      ADDR_SP:   sel_o = SEL_SP;
      ADDR_DPL:  sel_o = SEL_DPL;
      ADDR_DPH:  sel_o = SEL_DPH;
      ADDR_PCON: sel_o = SEL_PCON;
      ADDR_IE:   sel_o = SEL_IE;
      ADDR_IP:   sel_o = SEL_IP;
      ADDR_PSW:  sel_o = SEL_PSW;
      ADDR_ACC:  sel_o = SEL_ACC;
      ADDR_B:    sel_o = SEL_B;
      default:   mapped_o = 1'b0;
    endcase
    if (bit_access_i && !is_bit_row(byte_addr)) mapped_o = 1'b0;
  end

endmodule

// File: rtl/core_sfr_bank.sv
// SFR bank with byte/bit bus access and ALU flag loading into PSW.
// Build option SFR_PARITY_EN: PSW[0] tracks the XOR of ACC; otherwise it reads 0.
module core_sfr_bank
  import core_sfr_pkg::*;
(
  input  logic          sfr_clock_i,
  input  logic          sfr_reset_i,
  core_sfr_bank_if.slave bus,
  input  logic          sfr_alu_flags_we_i,
  input  logic          sfr_alu_cy_i,
  input  logic          sfr_alu_ac_i,
  input  logic          sfr_alu_ov_i,
  output logic [7:0]    sfr_acc_o,
  output logic [1:0]    sfr_psw_rs_o,
  output logic [7:0]    sfr_sp_o
);

  // state      | meaning
  // ST_IDLE    | waiting for a strobe; byte writes complete here
  // ST_RD_RESP | returning read data (byte or bit) with rdy
  // ST_BIT_RMW | writing back the latched byte with one bit replaced

  sfr_state_e state_q, state_d;
  sfr_sel_e   dec_sel, sel_q, sel_d, wr_idx;
  logic       dec_mapped, mapped_q, mapped_d;
  logic [2:0] dec_bit_idx, bit_idx_q, bit_idx_d;
  logic       is_bit_q, is_bit_d, bit_val_q, bit_val_d;
  logic [7:0] rmw_q, rmw_d, data_q, data_d;
  logic       rdy_q, rdy_d, err_q, err_d;
  logic [7:0] sfr_q [NUM_SFR];
  logic [7:0] sfr_d [NUM_SFR];
  logic       parity_w, rd_w, wr_w, wr_en;
  logic [7:0] wr_val, wr_mask, psw_cover, live_val, held_val;

  core_sfr_decode u_decode (
    .addr_i       (bus.sfr_addr_i),
    .bit_access_i (bus.sfr_bit_byte_flag_i),
    .sel_o        (dec_sel),
    .mapped_o     (dec_mapped),
    .bit_idx_o    (dec_bit_idx)
  );

`ifdef SFR_PARITY_EN
  assign parity_w = ^sfr_q[SEL_ACC];
`else
  assign parity_w = 1'b0;
`endif

  // PSW[0] is never stored, so OR-ing the parity in yields the visible byte
  assign live_val = sfr_q[dec_sel] | ((dec_sel == SEL_PSW) ? {7'b0, parity_w} : 8'h00);
  assign held_val = sfr_q[sel_q]   | ((sel_q   == SEL_PSW) ? {7'b0, parity_w} : 8'h00);

  assign rd_w = !bus.sfr_rd_i_b;
  assign wr_w = !bus.sfr_wr_i_b;

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    mapped_d  = mapped_q;
    bit_idx_d = bit_idx_q;
    is_bit_d  = is_bit_q;
    bit_val_d = bit_val_q;
    rmw_d     = rmw_q;
    data_d    = data_q;
    rdy_d     = 1'b0;
    err_d     = 1'b0;
    sfr_d     = sfr_q;
    wr_en     = 1'b0;
    wr_idx    = dec_sel;
    wr_val    = 8'h00;
    wr_mask   = 8'h00;
    psw_cover = 8'h00;

    case (state_q)
      ST_IDLE: begin
        sel_d     = dec_sel;
        mapped_d  = dec_mapped;
        bit_idx_d = dec_bit_idx;
        is_bit_d  = bus.sfr_bit_byte_flag_i;
        if (rd_w && wr_w) begin
          err_d = 1'b1;
        end else if (rd_w) begin
          state_d = ST_RD_RESP;
        end else if (wr_w && bus.sfr_bit_byte_flag_i) begin
          state_d   = ST_BIT_RMW;
          rmw_d     = live_val;
          bit_val_d = bus.sfr_data_i[0];
        end else if (wr_w) begin
          rdy_d = 1'b1;
          if (dec_mapped) begin
            wr_en   = 1'b1;
            wr_idx  = dec_sel;
            wr_val  = bus.sfr_data_i;
            wr_mask = 8'hFF;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_RD_RESP: begin
        state_d = ST_IDLE;
        rdy_d   = 1'b1;
        err_d   = rd_w || wr_w;
        if (!mapped_q) begin
          data_d = 8'h00;
          err_d  = 1'b1;
        end else if (is_bit_q) begin
          data_d = {7'b0, held_val[bit_idx_q]};
        end else begin
          data_d = held_val;
        end
      end
      ST_BIT_RMW: begin
        state_d = ST_IDLE;
        rdy_d   = 1'b1;
        err_d   = rd_w || wr_w;
        if (mapped_q) begin
          wr_en              = 1'b1;
          wr_idx             = sel_q;
          wr_val             = rmw_q;
          wr_val[bit_idx_q]  = bit_val_q;
          wr_mask            = 8'h01 << bit_idx_q;
        end else begin
          err_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (wr_en) sfr_d[wr_idx] = wr_val;

    // ALU flags only land on PSW bits the bus is not writing this cycle
    if (wr_en && (wr_idx == SEL_PSW)) psw_cover = wr_mask;
    if (sfr_alu_flags_we_i) begin
      if (!psw_cover[PSW_CY]) sfr_d[SEL_PSW][PSW_CY] = sfr_alu_cy_i;
      if (!psw_cover[PSW_AC]) sfr_d[SEL_PSW][PSW_AC] = sfr_alu_ac_i;
      if (!psw_cover[PSW_OV]) sfr_d[SEL_PSW][PSW_OV] = sfr_alu_ov_i;
    end
    sfr_d[SEL_PSW][PSW_P] = 1'b0;
  end

  always_ff @(posedge sfr_clock_i) begin
    if (sfr_reset_i) begin
      state_q   <= ST_IDLE;
      sel_q     <= SEL_P0;
      mapped_q  <= 1'b0;
      bit_idx_q <= 3'd0;
      is_bit_q  <= 1'b0;
      bit_val_q <= 1'b0;
      rmw_q     <= 8'h00;
      data_q    <= 8'h00;
      rdy_q     <= 1'b0;
      err_q     <= 1'b0;
      for (int i = 0; i < NUM_SFR; i++) sfr_q[i] <= sfr_rst_val(i);
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      mapped_q  <= mapped_d;
      bit_idx_q <= bit_idx_d;
      is_bit_q  <= is_bit_d;
      bit_val_q <= bit_val_d;
      rmw_q     <= rmw_d;
      data_q    <= data_d;
      rdy_q     <= rdy_d;
      err_q     <= err_d;
      sfr_q     <= sfr_d;
    end
  end

  assign bus.sfr_data_o = data_q;
  assign bus.sfr_rdy_o  = rdy_q;
  assign bus.sfr_err_o  = err_q;
  assign sfr_acc_o      = sfr_q[SEL_ACC];
  assign sfr_psw_rs_o   = sfr_q[SEL_PSW][PSW_RS1:PSW_RS0];
  assign sfr_sp_o       = sfr_q[SEL_SP];

endmodule

// File: tb/tb_core_sfr_bank.sv
// Directed bench for core_sfr_bank; PSW parity expectations follow SFR_PARITY_EN.
module tb_core_sfr_bank;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       alu_we = 1'b0, cy = 1'b0, ac = 1'b0, ov = 1'b0;
  logic [7:0] acc, sp;
  logic [1:0] rs;
  int         errors = 0;
  int         checks = 0;

`ifdef SFR_PARITY_EN
  localparam logic [7:0] PAR_5B = 8'h01;
`else
  localparam logic [7:0] PAR_5B = 8'h00;
`endif

  core_sfr_bank_if bus ();

  core_sfr_bank dut (
    .sfr_clock_i        (clk),
    .sfr_reset_i        (rst),
    .bus                (bus),
    .sfr_alu_flags_we_i (alu_we),
    .sfr_alu_cy_i       (cy),
    .sfr_alu_ac_i       (ac),
    .sfr_alu_ov_i       (ov),
    .sfr_acc_o          (acc),
    .sfr_psw_rs_o       (rs),
    .sfr_sp_o           (sp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_read(input string tag, input logic [7:0] addr, input logic bitf,
                         input logic [7:0] exp_data, input logic exp_err);
    @(negedge clk);
    bus.sfr_addr_i = addr; bus.sfr_bit_byte_flag_i = bitf; bus.sfr_rd_i_b = 1'b0;
    @(negedge clk);
    bus.sfr_rd_i_b = 1'b1;
    chk({tag, "_rdy_early"}, bus.sfr_rdy_o, 8'h00);
    @(negedge clk);
    chk({tag, "_rdy"}, bus.sfr_rdy_o, 8'h01);
    chk({tag, "_data"}, bus.sfr_data_o, exp_data);
    chk({tag, "_err"}, bus.sfr_err_o, exp_err);
  endtask

  task automatic do_write(input string tag, input logic [7:0] addr, input logic [7:0] data,
                          input logic exp_err);
    @(negedge clk);
    bus.sfr_addr_i = addr; bus.sfr_bit_byte_flag_i = 1'b0;
    bus.sfr_data_i = data; bus.sfr_wr_i_b = 1'b0;
    @(negedge clk);
    bus.sfr_wr_i_b = 1'b1;
    chk({tag, "_rdy"}, bus.sfr_rdy_o, 8'h01);
    chk({tag, "_err"}, bus.sfr_err_o, exp_err);
  endtask

  task automatic do_bit_write(input string tag, input logic [7:0] addr, input logic val,
                              input logic exp_err);
    @(negedge clk);
    bus.sfr_addr_i = addr; bus.sfr_bit_byte_flag_i = 1'b1;
    bus.sfr_data_i = {7'b0, val}; bus.sfr_wr_i_b = 1'b0;
    @(negedge clk);
    bus.sfr_wr_i_b = 1'b1;
    chk({tag, "_rdy_early"}, bus.sfr_rdy_o, 8'h00);
    @(negedge clk);
    chk({tag, "_rdy"}, bus.sfr_rdy_o, 8'h01);
    chk({tag, "_err"}, bus.sfr_err_o, exp_err);
  endtask

  initial begin
    bus.sfr_addr_i = 8'h00; bus.sfr_rd_i_b = 1'b1; bus.sfr_wr_i_b = 1'b1;
    bus.sfr_bit_byte_flag_i = 1'b0; bus.sfr_data_i = 8'h00;

    // reset state
    @(negedge clk); @(negedge clk);
    chk("rst_rdy", bus.sfr_rdy_o, 8'h00);
    chk("rst_err", bus.sfr_err_o, 8'h00);
    chk("rst_data", bus.sfr_data_o, 8'h00);
    chk("rst_sp", sp, 8'h07);
    chk("rst_acc", acc, 8'h00);
    chk("rst_rs", rs, 8'h00);
    rst = 1'b0;

    do_read("rd_sp", 8'h81, 1'b0, 8'h07, 1'b0);
    do_read("rd_p0", 8'h80, 1'b0, 8'hFF, 1'b0);

    // ACC writes and PSW parity
    do_write("wr_acc5a", 8'hE0, 8'h5A, 1'b0);
    chk("acc_5a", acc, 8'h5A);
    do_read("rd_psw_5a", 8'hD0, 1'b0, 8'h00, 1'b0);
    do_write("wr_acc5b", 8'hE0, 8'h5B, 1'b0);
    do_read("rd_psw_5b", 8'hD0, 1'b0, PAR_5B, 1'b0);

    // PSW[0] is read-only
    do_write("wr_acc0", 8'hE0, 8'h00, 1'b0);
    do_write("wr_psw01", 8'hD0, 8'h01, 1'b0);
    do_read("rd_psw_ro", 8'hD0, 1'b0, 8'h00, 1'b0);

    // bit write to RS1
    do_bit_write("bw_d4", 8'hD4, 1'b1, 1'b0);
    chk("bw_d4_rs", rs, 8'h02);
    do_read("rd_psw_10", 8'hD0, 1'b0, 8'h10, 1'b0);

    // unmapped accesses
    do_read("rd_90", 8'h90, 1'b0, 8'h00, 1'b1);
    do_write("wr_90", 8'h90, 8'h33, 1'b1);
    do_bit_write("bw_8b", 8'h8B, 1'b1, 1'b1);
    do_read("rd_p0_after", 8'h80, 1'b0, 8'hFF, 1'b0);
    do_read("rd_psw_after", 8'hD0, 1'b0, 8'h10, 1'b0);
    chk("sp_after", sp, 8'h07);

    // bus byte write wins over ALU flags
    @(negedge clk);
    bus.sfr_addr_i = 8'hD0; bus.sfr_bit_byte_flag_i = 1'b0;
    bus.sfr_data_i = 8'h00; bus.sfr_wr_i_b = 1'b0;
    alu_we = 1'b1; cy = 1'b1; ac = 1'b1; ov = 1'b1;
    @(negedge clk);
    bus.sfr_wr_i_b = 1'b1; alu_we = 1'b0;
    chk("bus_win_rdy", bus.sfr_rdy_o, 8'h01);
    do_read("rd_psw_buswin", 8'hD0, 1'b0, 8'h00, 1'b0);

    // ALU alone
    @(negedge clk);
    alu_we = 1'b1; cy = 1'b1; ac = 1'b1; ov = 1'b1;
    @(negedge clk);
    alu_we = 1'b0;
    do_read("rd_psw_alu", 8'hD0, 1'b0, 8'hC4, 1'b0);

    // bit write to CY against ALU in the write-back cycle
    @(negedge clk);
    bus.sfr_addr_i = 8'hD7; bus.sfr_bit_byte_flag_i = 1'b1;
    bus.sfr_data_i = 8'h00; bus.sfr_wr_i_b = 1'b0;
    @(negedge clk);
    bus.sfr_wr_i_b = 1'b1;
    alu_we = 1'b1; cy = 1'b1; ac = 1'b0; ov = 1'b0;
    @(negedge clk);
    alu_we = 1'b0;
    chk("bw_alu_rdy", bus.sfr_rdy_o, 8'h01);
    do_read("rd_psw_bwalu", 8'hD0, 1'b0, 8'h00, 1'b0);

    // bit reads
    do_read("brd_87", 8'h87, 1'b1, 8'h01, 1'b0);
    do_read("brd_e0", 8'hE0, 1'b1, 8'h00, 1'b0);

    // rd and wr together: no access, data held
    @(negedge clk);
    bus.sfr_addr_i = 8'hE0; bus.sfr_bit_byte_flag_i = 1'b0; bus.sfr_data_i = 8'hAA;
    bus.sfr_rd_i_b = 1'b0; bus.sfr_wr_i_b = 1'b0;
    @(negedge clk);
    bus.sfr_rd_i_b = 1'b1; bus.sfr_wr_i_b = 1'b1;
    chk("both_err", bus.sfr_err_o, 8'h01);
    chk("both_rdy", bus.sfr_rdy_o, 8'h00);
    chk("both_data", bus.sfr_data_o, 8'h00);
    chk("both_acc", acc, 8'h00);

    // reset aborts a bit write on ACC
    do_write("wr_sp30", 8'h81, 8'h30, 1'b0);
    do_write("wr_acc55", 8'hE0, 8'h55, 1'b0);
    @(negedge clk);
    bus.sfr_addr_i = 8'hE0; bus.sfr_bit_byte_flag_i = 1'b1;
    bus.sfr_data_i = 8'h00; bus.sfr_wr_i_b = 1'b0;
    @(negedge clk);
    bus.sfr_wr_i_b = 1'b1; rst = 1'b1;
    chk("abort_rdy0", bus.sfr_rdy_o, 8'h00);
    @(negedge clk);
    chk("abort_rdy1", bus.sfr_rdy_o, 8'h00);
    chk("abort_acc", acc, 8'h00);
    chk("abort_sp", sp, 8'h07);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_rdy2", bus.sfr_rdy_o, 8'h00);
    chk("abort_acc2", acc, 8'h00);

    // new strobe during RD_RESP
    @(negedge clk);
    bus.sfr_addr_i = 8'h81; bus.sfr_bit_byte_flag_i = 1'b0; bus.sfr_rd_i_b = 1'b0;
    @(negedge clk);
    bus.sfr_addr_i = 8'h80;
    chk("busy_rdy0", bus.sfr_rdy_o, 8'h00);
    @(negedge clk);
    bus.sfr_rd_i_b = 1'b1;
    chk("busy_rdy1", bus.sfr_rdy_o, 8'h01);
    chk("busy_err1", bus.sfr_err_o, 8'h01);
    chk("busy_data", bus.sfr_data_o, 8'h07);
    @(negedge clk);
    chk("busy_rdy2", bus.sfr_rdy_o, 8'h00);
    chk("busy_err2", bus.sfr_err_o, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
